// File: rtl/wb_regfile.sv
// Writeback-stage register file. It muxes the WB result, writes the integer register
// file, serves two decode read ports with same-cycle bypass, and counts retired instructions.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 64,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcW,
  input  logic             ValidW,
  input  logic [AW-1:0]    RdW,
  input  logic [XLEN-1:0]  ALUResultW,
  input  logic [XLEN-1:0]  ReadDataW,
  input  logic [XLEN-1:0]  PCPlus4W,
  input  logic [AW-1:0]    Rs1D,
  input  logic [AW-1:0]    Rs2D,
  output logic [XLEN-1:0]  RD1D,
  output logic [XLEN-1:0]  RD2D,
  output logic [XLEN-1:0]  ResultW,
  output logic             IllegalSrcW,
  output logic [CNT_W-1:0] InstRetCnt
);

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC4 = 2'b10;
  localparam logic [1:0] SRC_RSV = 2'b11;

  function automatic logic [XLEN-1:0] sel_result(input logic [1:0]      src,
                                                 input logic [XLEN-1:0] alu,
                                                 input logic [XLEN-1:0] mem,
                                                 input logic [XLEN-1:0] pc4);
    logic [XLEN-1:0] r;
    case (src)
      SRC_ALU: r = alu;
      SRC_MEM: r = mem;
      SRC_PC4: r = pc4;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Guards the array index when NREGS is not a power of two.
  function automatic logic idx_ok(input logic [AW-1:0] idx);
    return ({1'b0, idx} < (AW+1)'(NREGS));
  endfunction

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wr_en;
  logic             byp1;
  logic             byp2;

  assign ResultW     = sel_result(ResultSrcW, ALUResultW, ReadDataW, PCPlus4W);
  assign IllegalSrcW = RegWriteW & ValidW & (ResultSrcW == SRC_RSV);
  assign wr_en       = RegWriteW & ValidW & (RdW != '0) & (ResultSrcW != SRC_RSV)
                       & ~reset & idx_ok(RdW);
  assign byp1        = wr_en & (RdW == Rs1D);
  assign byp2        = wr_en & (RdW == Rs2D);
  assign cnt_d       = ValidW ? cnt_q + CNT_W'(1) : cnt_q;
  assign InstRetCnt  = cnt_q;

  always_comb begin
    RD1D = '0;
    RD2D = '0;
    if (!reset && Rs1D != '0 && idx_ok(Rs1D)) begin
      RD1D = byp1 ? ResultW : regs_q[Rs1D];
    end
    if (!reset && Rs2D != '0 && idx_ok(Rs2D)) begin
      RD2D = byp2 ? ResultW : regs_q[Rs2D];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[RdW] <= ResultW;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule
